// File: rtl/div_radix2.sv
// div_radix2: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   div_valid  divide request (held by EX while stalled)
//   signed_div 1 = DIV, 0 = DIVU; sampled with div_valid
//   opdata1    dividend (rs)
//   opdata2    divisor (rt)
//   cancel     flush/exception; aborts any operation in progress
//   result     {remainder -> HI, quotient -> LO}, registered
//   ready      one-cycle pulse when result is valid
//   stall_div  combinational pipeline hold request
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_valid,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_div
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic               sgn_q, sgn_d, neg1_q, neg1_d, neg2_q, neg2_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH:0]     trial, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix, abs1, abs2;
    // The shifted partial remainder can exceed WIDTH bits, so compare on WIDTH+1.
    assign trial   = {rem_q, quo_q[WIDTH-1]};
    assign diff    = trial - {1'b0, dvsr_q};
    assign ge      = trial >= {1'b0, dvsr_q};
    assign rem_nx  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ge};
    // Quotient negated when signs differ; remainder follows the dividend.
    assign quo_fix = (sgn_q & (neg1_q ^ neg2_q)) ? -quo_nx : quo_nx;
    assign rem_fix = (sgn_q & neg1_q) ? -rem_nx : rem_nx;
    assign abs1    = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign abs2    = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        sgn_d   = sgn_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        res_d   = res_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (div_valid) begin
                    sgn_d   = signed_div;
                    neg1_d  = signed_div & opdata1[WIDTH-1];
                    neg2_d  = signed_div & opdata2[WIDTH-1];
                    quo_d   = abs1;
                    dvsr_d  = abs2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (opdata2 == '0) ? DONE : BUSY;
                    if (opdata2 == '0) res_d = {opdata1, {WIDTH{1'b1}}};
                end
                BUSY: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        res_d   = {rem_fix, quo_fix};
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            sgn_q   <= 1'b0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            sgn_q   <= sgn_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            res_q   <= res_d;
        end
    end
    assign result    = res_q;
    assign ready     = (state_q == DONE) & ~cancel;
    assign stall_div = ~cancel & (((state_q == IDLE) & div_valid) | (state_q == BUSY));
endmodule
